// File: rtl/lsu_split_pkg.sv
// rtl/lsu_split_pkg.sv - shared access-size encodings, LSU state type and alignment helper
package lsu_split_pkg;

    localparam logic [1:0] DATA_BYTE        = 2'b00;
    localparam logic [1:0] DATA_HALF        = 2'b01;
    localparam logic [1:0] DATA_WORD        = 2'b10;
    localparam logic [1:0] DATA_DOUBLE_WORD = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'b00,
        LSU_BEAT0 = 2'b01,
        LSU_BEAT1 = 2'b10,
        LSU_RESP  = 2'b11
    } lsu_state_e;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size_type, input logic [2:0] addr_lo);
        logic [2:0] m;
        case (size_type)
            DATA_BYTE: m = 3'b000;
            DATA_HALF: m = 3'b001;
            DATA_WORD: m = 3'b011;
            default:   m = 3'b111;
        endcase
        return |(addr_lo & m);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane positioning and load extract/extend, purely combinational
module lsu_align
    import lsu_split_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int BE = DATA_WIDTH / 8,
    localparam int OFF_W = $clog2(BE)
) (
    input  logic [1:0]              type_i,
    input  logic                    sign_extend_i,
    input  logic [OFF_W-1:0]        offset_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH-1:0]   lo_i,
    input  logic [DATA_WIDTH-1:0]   hi_i,
    output logic [2*BE-1:0]         be_o,
    output logic [2*DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [2*BE-1:0]       mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  fill;
    int                    nbytes;

    always_comb begin
        nbytes = 32'(1) << type_i;
        mask   = '0;
        for (int i = 0; i < BE; i++) begin
            mask[i] = (i < nbytes);
        end
        be_o    = mask << offset_i;
        wdata_o = {{DATA_WIDTH{1'b0}}, wdata_i} << {offset_i, 3'b000};

        // Two-beat window shifted so the addressed byte lands in lane 0.
        shifted = DATA_WIDTH'({hi_i, lo_i} >> {offset_i, 3'b000});
        case (type_i)
            DATA_BYTE: fill = sign_extend_i & shifted[7];
            DATA_HALF: fill = sign_extend_i & shifted[15];
            DATA_WORD: fill = sign_extend_i & shifted[31];
            default:   fill = sign_extend_i & shifted[DATA_WIDTH-1];
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rdata_o[i] = (i < 8 * nbytes) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - multi-cycle load/store unit splitting boundary-crossing accesses into two beats
module lsu_split
    import lsu_split_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 32,
    parameter int SUPPORT_MISALIGNED = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    w_en_i,
    input  logic                    r_en_i,
    input  logic [1:0]              type_i,
    input  logic                    sign_extend_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    done_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    dmem_valid_o,
    input  logic                    dmem_ready_i,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] dmem_we_o,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);

    localparam int BE    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE);

    lsu_state_e            state_q, state_d;
    logic                  w_en_q, w_en_d;
    logic                  sign_q, sign_d;
    logic [1:0]            type_q, type_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] lo_buf_q, lo_buf_d;
    logic [DATA_WIDTH-1:0] hi_buf_q, hi_buf_d;

    logic [2*BE-1:0]         be_full;
    logic [2*DATA_WIDTH-1:0] wdata_full;
    logic [DATA_WIDTH-1:0]   load_data, lo_src, hi_src;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic                    split, illegal;

    // Completing beat's data is fed straight in so rdata can be registered on the same edge.
    assign lo_src = (state_q == LSU_BEAT0) ? dmem_rdata_i : lo_buf_q;
    assign hi_src = (state_q == LSU_BEAT1) ? dmem_rdata_i : hi_buf_q;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .type_i        (type_q),
        .sign_extend_i (sign_q),
        .offset_i      (addr_q[OFF_W-1:0]),
        .wdata_i       (wdata_q),
        .lo_i          (lo_src),
        .hi_i          (hi_src),
        .be_o          (be_full),
        .wdata_o       (wdata_full),
        .rdata_o       (load_data)
    );

    assign split     = |be_full[2*BE-1:BE];
    assign base_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign illegal   = ((type_i == DATA_DOUBLE_WORD) && (DATA_WIDTH == 32))
                     || ((SUPPORT_MISALIGNED == 0) && is_misaligned(type_i, addr_i[2:0]));

    always_comb begin
        state_d  = state_q;
        w_en_d   = w_en_q;
        sign_d   = sign_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        lo_buf_d = lo_buf_q;
        hi_buf_d = hi_buf_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i && (w_en_i || r_en_i)) begin
                    w_en_d   = w_en_i;
                    sign_d   = sign_extend_i;
                    type_d   = type_i;
                    addr_d   = addr_i;
                    wdata_d  = w_en_i ? wdata_i : '0;
                    err_d    = illegal;
                    rdata_d  = '0;
                    lo_buf_d = '0;
                    hi_buf_d = '0;
                    state_d  = illegal ? LSU_RESP : LSU_BEAT0;
                end
            end
            LSU_BEAT0: begin
                if (dmem_ready_i) begin
                    lo_buf_d = dmem_rdata_i;
                    if (split) begin
                        state_d = LSU_BEAT1;
                    end else begin
                        rdata_d = w_en_q ? '0 : load_data;
                        state_d = LSU_RESP;
                    end
                end
            end
            LSU_BEAT1: begin
                if (dmem_ready_i) begin
                    hi_buf_d = dmem_rdata_i;
                    rdata_d  = w_en_q ? '0 : load_data;
                    state_d  = LSU_RESP;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LSU_IDLE;
            w_en_q   <= 1'b0;
            sign_q   <= 1'b0;
            type_q   <= DATA_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            lo_buf_q <= '0;
            hi_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            w_en_q   <= w_en_d;
            sign_q   <= sign_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            lo_buf_q <= lo_buf_d;
            hi_buf_q <= hi_buf_d;
        end
    end

    // Outputs decode the state register alone, so an async reset clears them at once.
    assign req_ready_o  = (state_q == LSU_IDLE);
    assign dmem_valid_o = (state_q == LSU_BEAT0) || (state_q == LSU_BEAT1);
    assign done_o       = (state_q == LSU_RESP);
    assign err_o        = done_o & err_q;
    assign rdata_o      = done_o ? rdata_q : '0;

    assign dmem_addr_o  = (state_q == LSU_BEAT0) ? base_addr
                        : (state_q == LSU_BEAT1) ? base_addr + ADDR_WIDTH'(BE) : '0;
    assign dmem_we_o    = (state_q == LSU_BEAT0 && w_en_q) ? be_full[BE-1:0]
                        : (state_q == LSU_BEAT1 && w_en_q) ? be_full[2*BE-1:BE] : '0;
    assign dmem_wdata_o = (state_q == LSU_BEAT0) ? wdata_full[DATA_WIDTH-1:0]
                        : (state_q == LSU_BEAT1) ? wdata_full[2*DATA_WIDTH-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_lsu_split.sv
// tb/tb_lsu_split.sv - directed bench with byte-memory model and per-cycle compare for lsu_split
module tb_lsu_split;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, w_en = 0, r_en = 0, sext = 0;
    logic [1:0]  typ = 0;
    logic [31:0] addr = 0, wdata = 0;

    logic        req_ready, done, err, dvalid;
    logic        dready = 0;
    logic [31:0] rdata, daddr, dwdata;
    logic [31:0] drdata = 0;
    logic [3:0]  dwe;

    logic        b_req_ready, b_done, b_err, b_dvalid;
    logic [31:0] b_rdata, b_daddr, b_dwdata;
    logic [3:0]  b_dwe;

    lsu_split #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SUPPORT_MISALIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .w_en_i(w_en), .r_en_i(r_en), .type_i(typ), .sign_extend_i(sext),
        .addr_i(addr), .wdata_i(wdata), .done_o(done), .err_o(err), .rdata_o(rdata),
        .dmem_valid_o(dvalid), .dmem_ready_i(dready), .dmem_addr_o(daddr),
        .dmem_wdata_o(dwdata), .dmem_we_o(dwe), .dmem_rdata_i(drdata)
    );

    lsu_split #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SUPPORT_MISALIGNED(0)) dut_strict (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
        .w_en_i(w_en), .r_en_i(r_en), .type_i(typ), .sign_extend_i(sext),
        .addr_i(addr), .wdata_i(wdata), .done_o(b_done), .err_o(b_err), .rdata_o(b_rdata),
        .dmem_valid_o(b_dvalid), .dmem_ready_i(1'b1), .dmem_addr_o(b_daddr),
        .dmem_wdata_o(b_dwdata), .dmem_we_o(b_dwe), .dmem_rdata_i(32'hCAFEF00D)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [7:0] mem [1024];

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ix;
            ix = a + i;
            mem[ix[9:0]] = w[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ix;
            ix = a + i;
            w[8*i +: 8] = mem[ix[9:0]];
        end
        return w;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
    } beat_t;
    beat_t obs[$];

    int          cyc = 0;
    int          acc_cyc = -100;
    int          exp_done_cyc = -100;
    bit          exp_err = 0;
    logic [31:0] exp_rdata = 0;
    int          stall = 0;
    int          last_done_cyc = -1;
    logic [31:0] last_rdata = 0;
    int          b_done_cyc = -1;
    logic        b_err_seen = 0;
    logic [31:0] b_rdata_seen = 0;
    bit          b_bus_seen = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: stalls each beat for 'stall' cycles, then serves it.
    initial begin
        int    wait_cnt;
        beat_t ref_b;
        wait_cnt = 0;
        ref_b = '{a: 0, we: 0, wd: 0};
        forever begin
            @(negedge clk);
            if (!dvalid) begin
                dready = 0;
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    ref_b = '{a: daddr, we: dwe, wd: dwdata};
                end else begin
                    check("stable_addr", daddr, ref_b.a);
                    check("stable_we", dwe, ref_b.we);
                    check("stable_wdata", dwdata, ref_b.wd);
                end
                if (wait_cnt < stall) begin
                    dready = 0;
                    wait_cnt++;
                end else begin
                    dready = 1;
                    drdata = word_at(daddr);
                    obs.push_back('{a: daddr, we: dwe, wd: dwdata});
                    for (int j = 0; j < 4; j++) begin
                        if (dwe[j]) begin
                            logic [31:0] ix;
                            ix = daddr + j;
                            mem[ix[9:0]] = dwdata[8*j +: 8];
                        end
                    end
                    wait_cnt = 0;
                end
            end
        end
    end

    // Per-cycle compare against the transaction model.
    initial forever begin
        bit busy;
        @(negedge clk);
        busy = (cyc > acc_cyc) && (cyc <= exp_done_cyc);
        check("req_ready", req_ready, !busy);
        check("done", done, cyc == exp_done_cyc);
        if (!busy || exp_err || cyc == exp_done_cyc) check("bus_idle", dvalid, 0);
        else check("bus_active", dvalid, 1);
        if (done) begin
            check("err", err, exp_err);
            check("rdata", rdata, exp_rdata);
            last_done_cyc = cyc;
            last_rdata = rdata;
        end else begin
            check("err_low", err, 0);
        end
        if (b_dvalid) b_bus_seen = 1;
        if (b_done) begin
            b_done_cyc = cyc;
            b_err_seen = b_err;
            b_rdata_seen = b_rdata;
        end
    end

    task automatic txn(input bit st, input logic [1:0] t, input bit sx, input logic [31:0] a,
                       input logic [31:0] wd, input int stl, input int abort_at);
        int          size, off, nb, guard;
        bit          illegal;
        logic [63:0] v;
        @(posedge clk); #1;
        size = 1 << t;
        off = int'(a[1:0]);
        illegal = (t == 2'b11);
        nb = (off + size > 4) ? 2 : 1;
        v = 0;
        for (int i = 0; i < size; i++) begin
            logic [31:0] ix;
            ix = a + i;
            v[8*i +: 8] = mem[ix[9:0]];
        end
        if (sx && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 1);
        exp_rdata = (illegal || st) ? 32'd0 : v[31:0];
        exp_err = illegal;
        stall = stl;
        obs.delete();
        last_done_cyc = -1;
        b_done_cyc = -1;
        b_bus_seen = 0;
        acc_cyc = cyc;
        exp_done_cyc = cyc + (illegal ? 1 : nb * (stl + 1) + 1);
        req_valid = 1; w_en = st; r_en = !st; typ = t; sext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; w_en = 0; r_en = 0;
        if (abort_at >= 0) begin
            while (cyc < acc_cyc + abort_at) begin
                @(posedge clk); #1;
            end
            #1;
            check("abort_in_beat1_valid", dvalid, 1);
            check("abort_in_beat1_addr", daddr, 32'h104);
            acc_cyc = -100;
            exp_done_cyc = -100;
            rst_n = 0;
            #1;
            check("abort_valid", dvalid, 0);
            check("abort_done", done, 0);
            check("abort_err", err, 0);
            check("abort_we", dwe, 0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1;
            return;
        end
        guard = 0;
        while (cyc <= exp_done_cyc && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_cycle", last_done_cyc, exp_done_cyc);
        if (!illegal) begin
            check("beat_count", obs.size(), nb);
            for (int k = 0; k < obs.size() && k < nb; k++) begin
                logic [31:0] ea, ew;
                logic [3:0]  ewe;
                ea = {a[31:2], 2'b00} + 32'(4 * k);
                ewe = 0;
                ew = 0;
                for (int j = 0; j < 4; j++) begin
                    int n;
                    n = 4 * k + j - off;
                    if (st && n >= 0 && n < size) ewe[j] = 1;
                    if (n >= 0 && n < 4) ew[8*j +: 8] = wd[8*n +: 8];
                end
                check("beat_addr", obs[k].a, ea);
                check("beat_we", obs[k].we, ewe);
                if (st) check("beat_wdata", obs[k].wd, ew);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_valid", dvalid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", daddr, 0);
        check("rst_we", dwe, 0);
        check("rst_wdata", dwdata, 0);
        rst_n = 1;

        set_word(32'h100, 32'hDEADBEEF);
        txn(0, 2'b10, 0, 32'h100, 0, 0, -1);
        check("lw_rdata", last_rdata, 32'hDEADBEEF);
        check("lw_latency", last_done_cyc - acc_cyc, 2);
        check("lw_beat_addr", obs[0].a, 32'h100);
        check("lw_beat_we", obs[0].we, 4'b0000);
        check("strict_lw_rdata", b_rdata_seen, 32'hCAFEF00D);
        check("strict_lw_latency", b_done_cyc - acc_cyc, 2);

        set_word(32'h100, 32'h80011234);
        txn(0, 2'b01, 1, 32'h102, 0, 0, -1);
        check("lh_signed", last_rdata, 32'hFFFF8001);
        check("lh_beat_addr", obs[0].a, 32'h100);
        txn(0, 2'b01, 0, 32'h102, 0, 0, -1);
        check("lh_unsigned", last_rdata, 32'h00008001);

        txn(1, 2'b10, 0, 32'h103, 32'h11223344, 0, -1);
        check("sw_b0_addr", obs[0].a, 32'h100);
        check("sw_b0_we", obs[0].we, 4'b1000);
        check("sw_b0_wdata", obs[0].wd, 32'h44000000);
        check("sw_b1_addr", obs[1].a, 32'h104);
        check("sw_b1_we", obs[1].we, 4'b0111);
        check("sw_b1_wdata", obs[1].wd, 32'h00112233);
        check("sw_rdata_zero", last_rdata, 0);
        check("sw_mem_lo", word_at(32'h100), 32'h44011234);

        set_word(32'h100, 32'hAABBCCDD);
        set_word(32'h104, 32'h11223344);
        txn(0, 2'b10, 0, 32'h102, 0, 0, -1);
        check("lw_split", last_rdata, 32'h3344AABB);
        check("lw_split_latency", last_done_cyc - acc_cyc, 3);
        txn(0, 2'b10, 0, 32'h102, 0, 3, -1);
        check("lw_split_stall", last_rdata, 32'h3344AABB);
        check("lw_split_stall_latency", last_done_cyc - acc_cyc, 9);
        txn(0, 2'b00, 1, 32'h101, 0, 0, -1);
        check("lb_signed", last_rdata, 32'hFFFFFFCC);
        txn(1, 2'b00, 0, 32'h105, 32'h000000A5, 2, -1);
        check("sb_mem", word_at(32'h104), 32'h1122A544);

        txn(0, 2'b01, 0, 32'h101, 0, 0, -1);
        check("strict_lh_err", b_err_seen, 1);
        check("strict_lh_latency", b_done_cyc - acc_cyc, 1);
        check("strict_lh_rdata", b_rdata_seen, 0);
        check("strict_lh_no_bus", b_bus_seen, 0);
        txn(0, 2'b11, 0, 32'h100, 0, 0, -1);
        check("ld_err_latency", last_done_cyc - acc_cyc, 1);
        check("ld_no_beats", obs.size(), 0);
        check("strict_ld_err", b_err_seen, 1);
        check("strict_ld_no_bus", b_bus_seen, 0);

        set_word(32'h3FC, 32'h55667788);
        set_word(32'h000, 32'hAABB0011);
        txn(0, 2'b10, 0, 32'hFFFFFFFE, 0, 0, -1);
        check("wrap_rdata", last_rdata, 32'h00115566);
        check("wrap_b1_addr", obs[1].a, 32'h00000000);

        @(posedge clk); #1;
        req_valid = 1; w_en = 0; r_en = 0; addr = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        check("nop_ready", req_ready, 1);
        check("nop_valid", dvalid, 0);
        req_valid = 0;

        set_word(32'h100, 32'hAABBCCDD);
        txn(0, 2'b10, 0, 32'h102, 0, 5, 8);
        set_word(32'h000, 32'h0BADF00D);
        txn(0, 2'b10, 0, 32'h000, 0, 0, -1);
        check("post_reset_lw", last_rdata, 32'h0BADF00D);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
